uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NREQ` byte sources. It sits between the requesters and the transmitter; the transmitter is clocked by the baud tick generator. The arbiter grants the transmitter to one requester for a whole message, which ends at a byte flagged `last`. It sequences each byte with a one-cycle start pulse and waits for the transmitter's done tick before issuing the next byte.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DBIT`, 8: data bits per byte.
- `TIMEOUT`, 1024: idle-grant release limit in clk cycles. Used only with `UART_ARB_TIMEOUT_EN`.

- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in `NREQ`: requester i has a byte on `req_data[i]`.
- `req_data` in `NREQ`×`DBIT`: unpacked array of bytes, one per requester.
- `req_last` in `NREQ`: the presented byte ends the message.
- `req_ready` out `NREQ`: one-hot, one-cycle byte-accept pulse.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_data` out `DBIT`: registered byte. Held stable from `tx_start` until the next byte is accepted.
- `tx_done_tick` in 1: transmitter finished the stop bit.
- `grant_id` out `$clog2(NREQ)`: current or last owner.
- `busy` out 1: grant held, i.e. state is not `ARB_IDLE`.

## Operation
- FSM states are `ARB_IDLE`, `ARB_GRANT`, `ARB_START` and `ARB_WAIT`.
- **`ARB_IDLE`**: if any `req_valid` is high, pick the first valid index searching upward from `ptr` with wrap-around. Register it into `grant_id`, then go to `ARB_GRANT`. If none is valid, stay.
- **`ARB_GRANT`**: if `req_valid[grant_id]` is high:
  - drive `req_ready[grant_id]`=1 combinationally;
  - register `tx_data`←`req_data[grant_id]` and `last_q`←`req_last[grant_id]`;
  - go to `ARB_START`.
  - Otherwise hold the grant and stay in `ARB_GRANT`.
- **`ARB_START`**: `tx_start`=1 (Moore decode); go to `ARB_WAIT`.
- **`ARB_WAIT`**: wait for `tx_done_tick`. On the tick:
  - if `last_q`=1, set `ptr`←(`grant_id`+1) mod `NREQ` and go to `ARB_IDLE`;
  - otherwise go to `ARB_GRANT`.
- `tx_done_tick` is ignored outside `ARB_WAIT`.
- `req_ready` is never asserted for a requester that is not granted. It is never asserted while `req_valid` of that requester is low.
- Requesters other than the owner are never interleaved into a message.
- Reset values: state `ARB_IDLE`, `ptr`=0, `grant_id`=0, `tx_data`=0, `last_q`=0, `tx_start`=0, `req_ready`=0, `busy`=0.

## Timing
- Arbitration latency: `req_valid` high in cycle 0 while in `ARB_IDLE` gives:
  - cycle 1: `ARB_GRANT` with `grant_id` valid and `req_ready` high if valid is still high;
  - cycle 2: `tx_start`.
- Byte-to-byte within a message: `tx_done_tick` in cycle n gives `req_ready` at n+1 and `tx_start` at n+2.
- Next message: `tx_done_tick` on the last byte in cycle n gives `ARB_IDLE` at n+1 and the new `grant_id` at n+2.
- Simultaneous requests: the lowest index at or above `ptr` wins, with wrap-around.
- Wrap: after owner `NREQ`-1 finishes, `ptr`=0.
- Reset mid-message: on the next edge the arbiter is in the reset state and the grant is lost. A byte already in the transmitter is not aborted.
- The owner drops `req_valid` inside a message: the grant persists and no byte is issued.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- **Defined**: a counter of width `$clog2(TIMEOUT+1)` counts consecutive `ARB_GRANT` cycles with `req_valid[grant_id]`=0.
  - It clears on accept and on leaving `ARB_GRANT`.
  - When it reaches `TIMEOUT`-1, the arbiter goes to `ARB_IDLE` and sets `ptr`←`grant_id`+1, releasing the partial message.
- **Undefined**: there is no counter, and the grant is held indefinitely until the `last` byte completes.

## Structure
- The `uart_pkg` package gains the `arb_state` enum (`ARB_IDLE`, `ARB_GRANT`, `ARB_START`, `ARB_WAIT`).
- One sub-module, `rr_pick`, parameterized by `NREQ`. Inputs are the request vector and `ptr`; outputs are the winner index and an any-valid flag.
- The rest (FSM, registers, timeout) lives in `uart_tx_arbiter`.

## Test plan
1. **Single message**: requester 2 sends bytes 0x41, 0x42 with last on 0x42, and the transmitter model returns `tx_done_tick` 10 cycles after each `tx_start`.
   - Two `tx_start` pulses carry 0x41 then 0x42, and `req_ready[2]` pulses twice.
   - `busy` falls one cycle after the second done tick, and `ptr` becomes 3.
2. **Simultaneous requests**: all 4 requesters present single-byte messages 0x10..0x13 from reset.
   - Grant order is 0,1,2,3; then 0 again if re-requested.
3. **No interleaving**: requester 1 is granted with a 3-byte message while requester 0 is valid throughout.
   - Requester 0 is served only after 1's last byte, and only via the wrap from `ptr`=2.
4. **Owner stall**: the owner drops valid for 50 cycles mid-message.
   - Without the macro, no `tx_start` occurs and `grant_id` is unchanged.
   - With the macro and `TIMEOUT`=16, the grant is released after 16 cycles and the next requester is granted.
5. **Reset mid-`ARB_WAIT`**: `rst_n`=0 for 1 cycle.
   - All outputs take their reset values on the next edge.
   - A done tick arriving after reset produces no `req_ready`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_START,
    ARB_WAIT
  } arb_state;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to 0.
// Purely combinational, no handshake of its own.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] win_id,
  output logic                    any_valid
);

  localparam int IW = $clog2(NREQ);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    win_id    = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        win_id    = wrap_idx(ptr, k);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ sources, one whole message per grant; tx_start 2 cycles after
// valid from idle, req_ready combinational on owner valid. UART_ARB_TIMEOUT_EN releases a stalled grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [DBIT-1:0]         req_data [NREQ],
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_data,
  input  logic                    tx_done_tick,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);

  arb_state      state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win_id;
  logic [IW-1:0] gid_inc;
  logic          any_valid;
  logic          last_q;
  logic          own_vld;
  logic          accept;
  logic          timed_out;

  assign own_vld = req_valid[grant_id];
  assign accept  = (state == ARB_GRANT) && own_vld;
  assign gid_inc = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  assign timed_out = (state == ARB_GRANT) && !own_vld && (idle_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if ((state == ARB_GRANT) && !own_vld && !timed_out)
      idle_cnt <= idle_cnt + CW'(1);
    else
      idle_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timed_out      = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .win_id    (win_id),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (any_valid) state_nxt = ARB_GRANT;
      ARB_GRANT: begin
        if (own_vld)        state_nxt = ARB_START;
        else if (timed_out) state_nxt = ARB_IDLE;
      end
      ARB_START: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (tx_done_tick) state_nxt = last_q ? ARB_IDLE : ARB_GRANT;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    tx_start = (state == ARB_START);
    busy     = (state != ARB_IDLE);
  end

  // grant_id keeps the last owner while idle; ptr only moves when a grant ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      last_q   <= 1'b0;
    end else begin
      if ((state == ARB_IDLE) && any_valid) grant_id <= win_id;
      if (accept) begin
        tx_data <= req_data[grant_id];
        last_q  <= req_last[grant_id];
      end
      if (((state == ARB_WAIT) && tx_done_tick && last_q) || timed_out) ptr <= gid_inc;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a delayed-done transmitter model and a
// message-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int TMO  = 16;
  localparam int IW   = 2;

  typedef struct packed {
    logic            last;
    logic [DBIT-1:0] dat;
  } item_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [DBIT-1:0] req_data [NREQ];
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic            tx_start;
  logic [DBIT-1:0] tx_data;
  logic            tx_done_tick = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // stimulus state
  item_t sq [NREQ][$];
  int    stall_cnt [NREQ];
  bit    stall_rand = 0;
  bit    stray_en   = 0;
  bit    rnd_dly    = 0;
  int    rst_hold   = 0;
  int    tick_at    = -1;
  int    rdy_log [$];
  int    tx_log  [$];

  // reference model: message owner, pointer, and what the next cycles must show
  int              m_owner = -1;
  int              m_gid   = 0;
  int              m_ptr   = 0;
  bit              m_need  = 0;
  int              m_tstart = -1;
  bit              m_wait  = 0;
  bit              m_last  = 0;
  logic [DBIT-1:0] m_byte  = '0;
  int              m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] pack_log(input int q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = (r << 4) | 32'(q[i] & 15);
    return r;
  endfunction

  function automatic bit quiet();
    for (int i = 0; i < NREQ; i++) if (sq[i].size() != 0) return 0;
    return (m_owner < 0) && (cyc >= tick_at);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_ptr = 0; m_need = 0; m_tstart = -1;
    m_wait = 0; m_last = 0; m_byte = '0; m_cnt = 0;
  endtask

  task automatic push(input int r, input logic [DBIT-1:0] d, input bit l);
    sq[r].push_back({l, d});
  endtask

  task automatic drive();
    rst_n = (rst_hold == 0);
    if (rst_hold > 0) rst_hold--;
    for (int i = 0; i < NREQ; i++) begin
      if (stall_cnt[i] > 0) stall_cnt[i]--;
      else if (stall_rand && sq[i].size() != 0 && $urandom_range(0, 7) == 0)
        stall_cnt[i] = $urandom_range(1, 4);
      req_valid[i] = (sq[i].size() != 0) && (stall_cnt[i] == 0);
      req_data[i]  = (sq[i].size() != 0) ? sq[i][0].dat : '0;
      req_last[i]  = (sq[i].size() != 0) ? sq[i][0].last : 1'b0;
    end
    tx_done_tick = (cyc == tick_at) || (stray_en && !m_wait && $urandom_range(0, 7) == 0);
  endtask

  task automatic observe();
    logic [NREQ-1:0] exp_rdy;
    bit              exp_start;
    int              w;
    exp_rdy = '0;
    if (m_owner >= 0 && m_need && req_valid[m_owner]) exp_rdy[m_owner] = 1'b1;
    exp_start = (m_tstart == cyc);

    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("tx_start", 32'(tx_start), 32'(exp_start));
    if (exp_start) chk("tx_data", 32'(tx_data), 32'(m_byte));
    if (m_wait && tx_done_tick) chk("tx_data_hold", 32'(tx_data), 32'(m_byte));

    for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_log.push_back(i);
    if (tx_start) begin
      tx_log.push_back(int'(tx_data));
      tick_at = cyc + (rnd_dly ? int'($urandom_range(1, 12)) : 10);
    end
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && req_valid[i] && sq[i].size() != 0) void'(sq[i].pop_front());

    if (!rst_n) begin
      model_reset();
    end else if (exp_rdy != '0) begin
      m_byte = req_data[m_owner]; m_last = req_last[m_owner];
      m_need = 0; m_tstart = cyc + 1; m_cnt = 0;
    end else if (exp_start) begin
      m_tstart = -1; m_wait = 1;
    end else if (m_wait && tx_done_tick) begin
      m_wait = 0;
      if (m_last) begin m_ptr = (m_owner + 1) % NREQ; m_owner = -1; end
      else begin m_need = 1; m_cnt = 0; end
    end else if (m_owner < 0 && req_valid != '0) begin
      w = rr(req_valid, m_ptr);
      m_owner = w; m_gid = w; m_need = 1; m_cnt = 0;
    end
`ifdef UART_ARB_TIMEOUT_EN
    else if (m_owner >= 0 && m_need) begin
      if (m_cnt == TMO - 1) begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_need = 0; m_cnt = 0;
      end else m_cnt++;
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic run_quiet(input string tag, input int budget);
    int n = 0;
    while (!quiet() && n < budget) begin step(); n++; end
    chk(tag, 32'(n >= budget), 32'd0);
  endtask

  task automatic do_reset();
    rst_hold = 1;
    step();
    step();
  endtask

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) begin stall_cnt[i] = 0; req_data[i] = '0; end
    repeat (3) @(posedge clk);
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);

    // single two-byte message from requester 2, then ptr must sit at 3
    push(2, 8'h41, 0); push(2, 8'h42, 1);
    run_quiet("t1_drain", 200);
    chk("t1_ready_ids", pack_log(rdy_log), 32'h22);
    chk("t1_bytes", 32'((tx_log.size() == 2) ? ((tx_log[0] << 8) | tx_log[1]) : 0), 32'h4142);
    rdy_log.delete(); tx_log.delete();
    push(0, 8'h50, 1); push(3, 8'h53, 1);
    run_quiet("t1b_drain", 200);
    chk("t1_ptr_order", pack_log(rdy_log), 32'h30);

    // simultaneous single-byte messages from reset
    do_reset();
    rdy_log.delete(); tx_log.delete();
    for (int i = 0; i < NREQ; i++) push(i, 8'(8'h10 + i), 1);
    run_quiet("t2_drain", 400);
    chk("t2_order", pack_log(rdy_log), 32'h0123);
    chk("t2_bytes", pack_log(tx_log), 32'h0123);
    push(0, 8'h14, 1);
    run_quiet("t2b_drain", 200);
    chk("t2_regrant", 32'(rdy_log[rdy_log.size() - 1]), 32'd0);

    // no interleaving: requester 1 owns three bytes while 0 waits
    do_reset();
    push(0, 8'h20, 1);
    run_quiet("t3a_drain", 200);
    rdy_log.delete(); tx_log.delete();
    push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 1); push(0, 8'h21, 1);
    run_quiet("t3_drain", 400);
    chk("t3_order", pack_log(rdy_log), 32'h1110);
    chk("t3_last_byte", 32'(tx_log[3]), 32'h21);

    // owner stall inside a message
    rdy_log.delete(); tx_log.delete();
    push(1, 8'h61, 0); push(1, 8'h62, 0); push(1, 8'h63, 1); push(3, 8'h73, 1);
    n = 0;
    while (rdy_log.size() == 0 && n < 100) begin step(); n++; end
    chk("t4_first_accept", 32'(n >= 100), 32'd0);
    stall_cnt[1] = 51;
    repeat (40) step();
`ifdef UART_ARB_TIMEOUT_EN
    chk("t4_release", 32'((rdy_log.size() > 1) ? rdy_log[1] : -1), 32'd3);
`else
    chk("t4_stall_gid", 32'(grant_id), 32'd1);
    chk("t4_stall_starts", 32'(tx_log.size()), 32'd1);
`endif
    run_quiet("t4_drain", 400);
`ifdef UART_ARB_TIMEOUT_EN
    chk("t4_order", pack_log(rdy_log), 32'h1311);
`else
    chk("t4_order", pack_log(rdy_log), 32'h1113);
`endif

    // reset while waiting for the transmitter
    rdy_log.delete(); tx_log.delete();
    push(2, 8'h81, 0); push(2, 8'h82, 1);
    n = 0;
    while (tx_log.size() == 0 && n < 100) begin step(); n++; end
    chk("t5_first_start", 32'(n >= 100), 32'd0);
    repeat (3) step();
    stall_cnt[2] = 20;
    do_reset();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant", 32'(grant_id), 32'd0);
    chk("t5_tx_data", 32'(tx_data), 32'd0);
    chk("t5_start", 32'(tx_start), 32'd0);
    rdy_log.delete();
    repeat (12) step();
    chk("t5_no_ready", 32'(rdy_log.size()), 32'd0);
    run_quiet("t5_drain", 200);

    // randomized traffic with stalls, stray ticks and varying transmitter delay
    stall_rand = 1; stray_en = 1; rnd_dly = 1;
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        int r, len;
        r   = $urandom_range(0, NREQ - 1);
        len = $urandom_range(1, 4);
        if (sq[r].size() < 8)
          for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
      end
      step();
    end
    stray_en = 0;
    run_quiet("t6_drain", 3000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
